// File: rtl/uart_pkg.sv
// Shared types for the UART blocks: transmitter state, parity mode and data-width encodings.
// The helper functions decode the raw config fields into these types.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  // The encoding 2'b11 also means no parity.
  function automatic parity_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // XOR of the low (dbits+5) bits of data.
  function automatic logic data_parity(input logic [7:0] data, input logic [1:0] dbits);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - dbits);
    return ^(data & mask);
  endfunction

endpackage

// File: rtl/uart_baud.sv
// Baud generator: one baud_sample_16th pulse every cfg_div+1 clocks; clear restarts the phase.
module uart_baud (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_div,
  input  logic        clear,
  output logic        baud_sample_16th
);

  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_cnt <= '0;
    end else if (r_cnt >= cfg_div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign baud_sample_16th = !clear && (r_cnt >= cfg_div);

endmodule

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO: rdata always presents the head entry.
// Pointers wrap modulo DEPTH; occupancy lives in its own count register.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO: configurable 5-8 data bits, parity, 1/2 stop bits, break.
// Frame format is latched at pop so config changes never corrupt a frame in flight.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cfg_div,
  input  logic             cfg_txen,
  input  logic             cfg_nstop,
  input  logic [1:0]       cfg_dbits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_break,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic [CNT_W-1:0] tx_level,
  output logic             tx_busy,
  output logic             uart_txd
);

  tx_state_e  r_state;
  tx_state_e  w_next;
  logic       r_rdy_en;
  logic [3:0] r_sub;
  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic       r_stopcnt;
  logic       r_mab;
  logic [1:0] r_dbits;
  parity_e    r_par;
  logic       r_nstop;
  logic       r_par_bit;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_tick;
  logic       w_bit_end;
  logic       w_baud_clr;
  logic       w_mab_set;
  logic [7:0] w_rdata;

  assign tx_ready = r_rdy_en && !w_full;
  assign w_push   = tx_valid && tx_ready;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (tx_data),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (tx_level)
  );

  uart_baud u_baud (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_div          (cfg_div),
    .clear            (w_baud_clr),
    .baud_sample_16th (w_tick)
  );

  // A bit period ends on the 16th sample tick.
  assign w_bit_end = w_tick && (r_sub == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_baud_clr = 1'b0;
    w_mab_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_break) begin
          w_next = ST_BREAK;
        end else if (cfg_txen && !w_empty) begin
          w_pop      = 1'b1;
          w_baud_clr = 1'b1;
          w_next     = ST_START;
        end
      end
      ST_START:  if (w_bit_end) w_next = ST_DATA;
      ST_DATA: begin
        if (w_bit_end && (r_bitcnt == (3'(r_dbits) + 3'd4))) begin
          w_next = (r_par != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (w_bit_end) w_next = ST_STOP;
      ST_STOP:   if (w_bit_end && (!r_nstop || r_stopcnt)) w_next = ST_IDLE;
      ST_BREAK: begin
        // Release of break starts one full mark-after-break bit.
        if (!r_mab && !cfg_break) begin
          w_mab_set  = 1'b1;
          w_baud_clr = 1'b1;
        end else if (r_mab && w_bit_end) begin
          w_next = ST_IDLE;
        end
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy_en  <= 1'b0;
      r_sub     <= '0;
      r_shift   <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_mab     <= 1'b0;
      r_dbits   <= DBITS_8;
      r_par     <= PAR_NONE;
      r_nstop   <= 1'b0;
      r_par_bit <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_baud_clr)  r_sub <= '0;
      else if (w_tick) r_sub <= r_sub + 4'd1;
      if (w_pop) begin
        r_shift   <= w_rdata;
        r_dbits   <= cfg_dbits;
        r_par     <= decode_parity(cfg_parity);
        r_nstop   <= cfg_nstop;
        r_par_bit <= data_parity(w_rdata, cfg_dbits) ^ (decode_parity(cfg_parity) == PAR_ODD);
        r_bitcnt  <= '0;
        r_stopcnt <= 1'b0;
      end else if (w_bit_end) begin
        if (r_state == ST_DATA) begin
          r_shift  <= r_shift >> 1;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (r_state == ST_STOP) r_stopcnt <= 1'b1;
      end
      if (w_mab_set)                 r_mab <= 1'b1;
      else if (r_state != ST_BREAK)  r_mab <= 1'b0;
    end
  end

  always_comb begin
    uart_txd = 1'b1;
    case (r_state)
      ST_START:  uart_txd = 1'b0;
      ST_DATA:   uart_txd = r_shift[0];
      ST_PARITY: uart_txd = r_par_bit;
      ST_BREAK:  uart_txd = r_mab;
      default:   uart_txd = 1'b1;
    endcase
  end

  assign tx_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed frames, FIFO fill, break, reset abort and randomized frames
// checked cycle by cycle against a bit-list model of each frame.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 2000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      cfg_div;
  logic             cfg_txen;
  logic             cfg_nstop;
  logic [1:0]       cfg_dbits;
  logic [1:0]       cfg_parity;
  logic             cfg_break;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready;
  logic [CNT_W-1:0] tx_level;
  logic             tx_busy;
  logic             uart_txd;

  always #5 clk = ~clk;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_div    (cfg_div),
    .cfg_txen   (cfg_txen),
    .cfg_nstop  (cfg_nstop),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_break  (cfg_break),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_level   (tx_level),
    .tx_busy    (tx_busy),
    .uart_txd   (uart_txd)
  );

  logic [0:0] exp_q[$];
  int         len_q[$];
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (errors <= 40) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame, one entry per bit period.
  task automatic model_frame(input logic [7:0] d, input logic [1:0] dbits,
                             input logic [1:0] par, input logic nstop);
    int n;
    int ones;
    int len;
    n    = int'(dbits) + 5;
    ones = 0;
    len  = 0;
    exp_q.push_back(1'b0); len++;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]); len++;
      if (d[i]) ones++;
    end
    if (par == 2'b01) begin exp_q.push_back((ones % 2) == 1); len++; end
    if (par == 2'b10) begin exp_q.push_back((ones % 2) == 0); len++; end
    exp_q.push_back(1'b1); len++;
    if (nstop) begin exp_q.push_back(1'b1); len++; end
    len_q.push_back(len);
  endtask

  task automatic push_byte(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    while (uart_txd !== 1'b0 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check("start_seen", uart_txd, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int p);
    int   n;
    logic b;
    n = (len_q.size() > 0) ? len_q.pop_front() : 0;
    for (int i = 0; i < n; i++) begin
      b = exp_q.pop_front();
      for (int c = 0; c < p; c++) begin
        check({tag, "_txd"}, uart_txd, b);
        check({tag, "_busy"}, tx_busy, 1'b1);
        @(negedge clk);
      end
    end
  endtask

  task automatic set_cfg(input logic [15:0] div, input logic [1:0] dbits,
                         input logic [1:0] par, input logic nstop);
    cfg_div    = div;
    cfg_dbits  = dbits;
    cfg_parity = par;
    cfg_nstop  = nstop;
  endtask

  initial begin
    int         waited;
    int         p;
    logic [7:0] bytes [9];
    logic [7:0] d;
    logic [1:0] rd;
    logic [1:0] rp;
    logic       rn;

    rst_n = 1'b0; cfg_txen = 1'b1; cfg_break = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    set_cfg(16'd0, 2'b11, 2'b00, 1'b0);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_level", tx_level, 0);
    check("rst_busy", tx_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", tx_ready, 1'b1);

    // 1: 8N1 0xA5, 16 clk per bit, busy for 160 clk
    model_frame(8'hA5, 2'b11, 2'b00, 1'b0);
    push_byte(8'hA5);
    wait_start(waited);
    check_frame("t1", 16);
    check("t1_busy_end", tx_busy, 1'b0);
    check("t1_idle_txd", uart_txd, 1'b1);

    // 2: 7E2 and 7O2 with 0x35
    set_cfg(16'd0, 2'b10, 2'b01, 1'b1);
    model_frame(8'h35, 2'b10, 2'b01, 1'b1);
    push_byte(8'h35);
    wait_start(waited);
    check_frame("t2e", 16);
    set_cfg(16'd0, 2'b10, 2'b10, 1'b1);
    model_frame(8'h35, 2'b10, 2'b10, 1'b1);
    push_byte(8'h35);
    wait_start(waited);
    check_frame("t2o", 16);
    check("t2_busy_end", tx_busy, 1'b0);

    // 3: fill FIFO with txen=0, then drain back to back
    set_cfg(16'd0, 2'b11, 2'b00, 1'b0);
    cfg_txen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bytes[k] = 8'($urandom_range(0, 255));
      check("t3_ready", tx_ready, (k < DEPTH) ? 1'b1 : 1'b0);
      push_byte(bytes[k]);
    end
    check("t3_level", tx_level, DEPTH);
    check("t3_ready_full", tx_ready, 1'b0);
    repeat (20) begin
      check("t3_txd_hold", uart_txd, 1'b1);
      @(negedge clk);
    end
    for (int k = 0; k < DEPTH; k++) model_frame(bytes[k], 2'b11, 2'b00, 1'b0);
    cfg_txen = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      wait_start(waited);
      check("t3_gap", (waited <= 1), 1'b1);
      check_frame("t3", 16);
    end
    check("t3_level_end", tx_level, 0);
    check("t3_busy_end", tx_busy, 1'b0);

    // 4: 5N1 0xFF, 7 bit periods
    set_cfg(16'd0, 2'b00, 2'b00, 1'b0);
    model_frame(8'hFF, 2'b00, 2'b00, 1'b0);
    push_byte(8'hFF);
    wait_start(waited);
    check_frame("t4", 16);
    check("t4_busy_end", tx_busy, 1'b0);

    // 5: break for 40 clk, then 16 clk mark-after-break
    cfg_break = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("t5_brk_txd", uart_txd, 1'b0);
      check("t5_brk_busy", tx_busy, 1'b1);
    end
    cfg_break = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t5_mab_txd", uart_txd, 1'b1);
      check("t5_mab_busy", tx_busy, 1'b1);
    end
    @(negedge clk);
    check("t5_idle_busy", tx_busy, 1'b0);

    // Randomized frames; format changes mid-frame must not affect the frame in flight
    for (int f = 0; f < 6; f++) begin
      rd = 2'($urandom_range(0, 3));
      rp = 2'($urandom_range(0, 3));
      rn = 1'($urandom_range(0, 1));
      d  = 8'($urandom_range(0, 255));
      set_cfg(16'($urandom_range(0, 2)), rd, rp, rn);
      p = 16 * (int'(cfg_div) + 1);
      model_frame(d, rd, rp, rn);
      push_byte(d);
      wait_start(waited);
      cfg_dbits  = 2'($urandom_range(0, 3));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_nstop  = 1'($urandom_range(0, 1));
      check_frame("rnd", p);
      check("rnd_busy_end", tx_busy, 1'b0);
    end

    // 6: reset during DATA with 3 bytes queued
    set_cfg(16'd0, 2'b11, 2'b00, 1'b0);
    for (int k = 0; k < 4; k++) push_byte(8'($urandom_range(0, 255)));
    check("t6_level", tx_level, 3);
    repeat (20) @(negedge clk);
    check("t6_busy_mid", tx_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_txd", uart_txd, 1'b1);
    check("t6_level_rst", tx_level, 0);
    check("t6_busy_rst", tx_busy, 1'b0);
    check("t6_ready_rst", tx_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_ready_back", tx_ready, 1'b1);
    repeat (40) begin
      check("t6_txd_idle", uart_txd, 1'b1);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
